// File: rtl/text_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : text_overlay
//  Description : Character-cell text renderer. Holds a COLS x ROWS buffer of
//                8-bit codes written through a host command port, and turns
//                the glyph generator's one-hot pixel vector into a single
//                text-pixel bit with blink and cursor-inversion attributes.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_overlay #(
    parameter int COLS         = 128,
    parameter int ROWS         = 64,
    parameter int BLINK_FRAMES = 30,
    parameter bit CURSOR_EN    = 1'b1,
    localparam int CW          = $clog2(COLS),
    localparam int RW          = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blank,
    input  logic          vsync,
    input  logic [7:0]    char_x,
    input  logic [7:0]    char_y,
    input  logic [255:0]  ascii_char,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [15:0]   cmd_data,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          pix_on
);

    localparam int AW     = CW + RW;
    localparam int DEPTH  = COLS * ROWS;
    localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] c_op_putc   = 2'b00;
    localparam logic [1:0] c_op_setcur = 2'b01;
    localparam logic [1:0] c_op_clear  = 2'b10;
    localparam logic [7:0] c_space     = 8'h20;
    localparam logic [7:0] c_newline   = 8'h0A;
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [FW-1:0] c_last_frame = FW'(BLINK_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_addr;
    logic [AW-1:0] w_clr_addr_next;
    logic [CW-1:0] r_cur_col;
    logic [RW-1:0] r_cur_row;
    logic [CW-1:0] w_col_next;
    logic [RW-1:0] w_row_next;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;

    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_rdata;
    logic [AW-1:0] w_raddr;

    logic          w_in_range;
    logic          w_is_cursor;
    logic          r_in_range_d1;
    logic          r_blank_d1;
    logic          r_is_cursor_d1;

    logic          r_vsync_d;
    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_phase;

    logic [127:0]  w_glyph_bank;
    logic          w_glyph;
    logic          w_blink_hide;
    logic          w_unused_hi;

    assign cur_col = r_cur_col;
    assign cur_row = r_cur_row;

    // State, clear address and cursor registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_cur_col  <= '0;
            r_cur_row  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
            r_cur_col  <= w_col_next;
            r_cur_row  <= w_row_next;
        end
    end

    // Command decode, clear sweep and buffer write-port selection.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_col_next      = r_cur_col;
        w_row_next      = r_cur_row;
        cmd_ready       = 1'b0;
        w_we            = 1'b0;
        w_waddr         = {r_cur_row, r_cur_col};
        w_wdata         = cmd_data[7:0];
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = c_space;
                if (r_clr_addr == c_last_addr) begin
                    w_state_next    = ST_IDLE;
                    w_clr_addr_next = '0;
                end else begin
                    w_clr_addr_next = r_clr_addr + 1'b1;
                end
            end
            default: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        c_op_putc: begin
                            // Row and column widths are exact powers of two,
                            // so +1 wraps naturally at the buffer edges.
                            if (cmd_data[7:0] == c_newline) begin
                                w_col_next = '0;
                                w_row_next = r_cur_row + 1'b1;
                            end else begin
                                w_we       = 1'b1;
                                w_col_next = r_cur_col + 1'b1;
                                if (r_cur_col == CW'(COLS - 1)) begin
                                    w_row_next = r_cur_row + 1'b1;
                                end
                            end
                        end
                        c_op_setcur: begin
                            if (({24'd0, cmd_data[7:0]} < 32'(COLS)) &&
                                ({24'd0, cmd_data[15:8]} < 32'(ROWS))) begin
                                w_col_next = cmd_data[CW-1:0];
                                w_row_next = cmd_data[8 +: RW];
                            end
                        end
                        c_op_clear: begin
                            w_col_next      = '0;
                            w_row_next      = '0;
                            w_clr_addr_next = '0;
                            w_state_next    = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Screen buffer: single write port, registered read returning old data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rdata <= r_mem[w_raddr];
    end

    assign w_raddr     = {char_y[RW-1:0], char_x[CW-1:0]};
    assign w_in_range  = ({24'd0, char_x} < 32'(COLS)) && ({24'd0, char_y} < 32'(ROWS));
    assign w_is_cursor = w_in_range && (char_x[CW-1:0] == r_cur_col) &&
                         (char_y[RW-1:0] == r_cur_row);

    // Pixel attributes travelling alongside the buffer read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_range_d1  <= 1'b0;
            r_blank_d1     <= 1'b0;
            r_is_cursor_d1 <= 1'b0;
        end else begin
            r_in_range_d1  <= w_in_range;
            r_blank_d1     <= blank;
            r_is_cursor_d1 <= w_is_cursor;
        end
    end

    // Only the lower 128 glyphs are addressable; bit 7 of a code is blink.
    assign w_glyph_bank = ascii_char[127:0];
    assign w_unused_hi  = ^ascii_char[255:128];
    assign w_glyph      = w_glyph_bank[r_rdata[6:0]];
    assign w_blink_hide = r_rdata[7] & r_blink_phase;

    // Final text-pixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on <= 1'b0;
        end else begin
            pix_on <= !r_blank_d1 && r_in_range_d1 &&
                      ((w_glyph && !w_blink_hide) ^
                       (CURSOR_EN && r_is_cursor_d1 && r_blink_phase));
        end
    end

    // Blink timebase: count vsync rising edges, toggle phase on wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_d     <= 1'b0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            if (vsync && !r_vsync_d) begin
                if (r_frame_cnt == c_last_frame) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= !r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_overlay
//  Description : Directed self-checking bench for text_overlay on a 4x2
//                buffer with a two-frame blink period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_overlay;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int CW   = 2;
    localparam int RW   = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          blank;
    logic          vsync;
    logic [7:0]    char_x;
    logic [7:0]    char_y;
    logic [255:0]  ascii_char;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [15:0]   cmd_data;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          pix_on;

    int tests = 0;
    int fails = 0;

    text_overlay #(
        .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(2), .CURSOR_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .blank(blank), .vsync(vsync),
        .char_x(char_x), .char_y(char_y), .ascii_char(ascii_char),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cur_col(cur_col), .cur_row(cur_row),
        .pix_on(pix_on)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] onehot(input int k);
        logic [255:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Present one pixel and return its text bit two cycles later.
    task automatic probe(input logic [7:0] x, input logic [7:0] y, input logic b,
                         input logic [255:0] glyphs, output logic p);
        char_x = x;
        char_y = y;
        blank  = b;
        tick();
        ascii_char = glyphs;
        tick();
        p     = pix_on;
        blank = 1'b0;
    endtask

    // Issue one command; wait_cycles reports how long cmd_ready stayed low.
    task automatic send(input logic [1:0] op, input logic [15:0] data, output int wait_cycles);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("cmd_accept_timeout", 32'(n < 100), 32'd1);
        tick();
        cmd_valid   = 1'b0;
        wait_cycles = n;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic count_clear(output int n);
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic p;
        int   w;
        reset      = 1'b1;
        blank      = 1'b0;
        vsync      = 1'b0;
        char_x     = '0;
        char_y     = '0;
        ascii_char = '0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_data   = '0;
        tick();
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pix_on",    32'(pix_on),    32'd0);
        check("rst_cur",       {30'd0, cur_row, cur_col}, 32'd0);

        // Initial clear lasts exactly COLS*ROWS cycles
        reset = 1'b0;
        count_clear(w);
        check("init_clear_len", 32'(w), 32'd8);
        check("ready_after_clear", 32'(cmd_ready), 32'd1);

        // Every cell reads back as a space
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                probe(8'(c), 8'(r), 1'b0, onehot(8'h20), p);
                check($sformatf("space_%0d_%0d", c, r), 32'(p), 32'd1);
            end
        end

        // PUTC 'A' at (0,0), then glyph lookup and blanking
        send(2'b00, 16'h0041, w);
        check("cur_after_putc", {30'd0, cur_row, cur_col}, 32'd1);
        probe(8'd0, 8'd0, 1'b0, onehot(8'h41), p);
        check("glyph_A_on", 32'(p), 32'd1);
        probe(8'd0, 8'd0, 1'b0, onehot(8'h42), p);
        check("glyph_B_off", 32'(p), 32'd0);
        probe(8'd0, 8'd0, 1'b1, onehot(8'h41), p);
        check("blank_off", 32'(p), 32'd0);

        // Out-of-range coordinates
        probe(8'd4, 8'd0, 1'b0, '1, p);
        check("oor_col", 32'(p), 32'd0);
        probe(8'd0, 8'd2, 1'b0, '1, p);
        check("oor_row", 32'(p), 32'd0);

        // Eight PUTCs from (0,0) wrap the cursor back to (0,0)
        send(2'b01, 16'h0000, w);
        for (int i = 0; i < 8; i++) begin
            send(2'b00, 16'(8'h30 + i), w);
            if (i == 3) check("cur_col_wrap", {30'd0, cur_row, cur_col}, 32'h4);
        end
        check("cur_full_wrap", {30'd0, cur_row, cur_col}, 32'd0);
        probe(8'd1, 8'd1, 1'b0, onehot(8'h35), p);
        check("cell_1_1_is_35", 32'(p), 32'd1);
        probe(8'd1, 8'd1, 1'b0, onehot(8'h34), p);
        check("cell_1_1_not_34", 32'(p), 32'd0);

        // SETCUR bounds and newline
        send(2'b01, 16'h0102, w);
        check("setcur_2_1", {30'd0, cur_row, cur_col}, 32'h6);
        send(2'b01, 16'h0005, w);
        check("setcur_col_oor", {30'd0, cur_row, cur_col}, 32'h6);
        send(2'b01, 16'h0200, w);
        check("setcur_row_oor", {30'd0, cur_row, cur_col}, 32'h6);
        send(2'b00, 16'h000A, w);
        check("newline_wrap", {30'd0, cur_row, cur_col}, 32'd0);
        probe(8'd2, 8'd1, 1'b0, onehot(8'h36), p);
        check("newline_no_write", 32'(p), 32'd1);
        send(2'b01, 16'h0103, w);
        check("setcur_3_1", {30'd0, cur_row, cur_col}, 32'h7);

        // CLEAR followed by a PUTC held off until the clear completes
        send(2'b10, 16'h0000, w);
        send(2'b00, 16'h00C1, w);
        check("putc_held_wait", 32'(w), 32'd8);
        tick();
        tick();
        check("putc_single_write", {30'd0, cur_row, cur_col}, 32'd1);

        // Blink: visible after 0 and 1 edges, hidden after 2, visible after 4
        probe(8'd0, 8'd0, 1'b0, onehot(8'h41), p);
        check("blink_0_edges", 32'(p), 32'd1);
        probe(8'd1, 8'd0, 1'b0, onehot(8'h20), p);
        check("cursor_phase0", 32'(p), 32'd1);
        vsync_pulse();
        probe(8'd0, 8'd0, 1'b0, onehot(8'h41), p);
        check("blink_1_edge", 32'(p), 32'd1);
        vsync_pulse();
        probe(8'd0, 8'd0, 1'b0, onehot(8'h41), p);
        check("blink_2_edges", 32'(p), 32'd0);
        probe(8'd1, 8'd0, 1'b0, onehot(8'h20), p);
        check("cursor_inv_glyph", 32'(p), 32'd0);
        probe(8'd1, 8'd0, 1'b0, '0, p);
        check("cursor_inv_blank", 32'(p), 32'd1);
        probe(8'd2, 8'd0, 1'b0, '0, p);
        check("noncursor_phase1", 32'(p), 32'd0);
        vsync_pulse();
        probe(8'd0, 8'd0, 1'b0, onehot(8'h41), p);
        check("blink_3_edges", 32'(p), 32'd0);
        vsync_pulse();
        probe(8'd0, 8'd0, 1'b0, onehot(8'h41), p);
        check("blink_4_edges", 32'(p), 32'd1);
        probe(8'd1, 8'd0, 1'b0, onehot(8'h20), p);
        check("cursor_phase0_again", 32'(p), 32'd1);

        // Reset pulse in mid-clear restarts a full clear
        send(2'b01, 16'h0103, w);
        send(2'b00, 16'h0055, w);
        probe(8'd3, 8'd1, 1'b0, onehot(8'h55), p);
        check("cell_3_1_is_55", 32'(p), 32'd1);
        send(2'b10, 16'h0000, w);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midclear_rst_ready", 32'(cmd_ready), 32'd0);
        count_clear(w);
        check("midclear_restart_len", 32'(w), 32'd8);
        probe(8'd3, 8'd1, 1'b0, onehot(8'h20), p);
        check("cell_3_1_cleared", 32'(p), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
